// File: rtl/delay_pkg.sv
// delay_pkg: shared types and helpers for the delay timer bank.
//   state_e          per-channel FSM state (IDLE, RUN, FIRE)
//   DEFAULT_TICK_DIV clock cycles per tick (1 s at 50 MHz)
//   pre_width()      prescaler width for a given TICK_DIV (at least 1 bit)
package delay_pkg;

    localparam int unsigned DEFAULT_TICK_DIV = 50_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } state_e;

    // $clog2(1) is 0, so keep one bit for the degenerate TICK_DIV=1 case.
    function automatic int unsigned pre_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/delay_channel.sv
// delay_channel: one timer channel (FSM + prescaler + tick down-counter).
//   clk, rst_n    clock, asynchronous active-low reset
//   start_i       load/restart with delay_i (wins over abort_i)
//   abort_i       cancel a running count, no pulse
//   periodic_i    reload latched delay on leaving FIRE (tie low for one-shot)
//   delay_i       delay in ticks
//   timeout_o     one-cycle expiry pulse (state FIRE)
//   busy_o        counting (state RUN)
//   remaining_o   ticks left
module delay_channel
    import delay_pkg::*;
#(
    parameter int unsigned DELAY_W  = 32,
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               periodic_i,
    input  logic [DELAY_W-1:0] delay_i,
    output logic               timeout_o,
    output logic               busy_o,
    output logic [DELAY_W-1:0] remaining_o
);

    localparam int unsigned PRE_W = pre_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DELAY_W-1:0] rem_q, rem_d;
    logic [DELAY_W-1:0] dly_q, dly_d;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rem_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        dly_d   = dly_q;

        if (start_i) begin
            // Start in any state (re)loads; it also pre-empts an expiry this cycle.
            dly_d   = delay_i;
            pre_d   = '0;
            rem_d   = delay_i;
            state_d = (delay_i == '0) ? FIRE : RUN;
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    if (abort_i) begin
                        state_d = IDLE;
                        pre_d   = '0;
                        rem_d   = '0;
                    end else if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        rem_d = rem_q - DELAY_W'(1);
                        if (rem_q == DELAY_W'(1)) begin
                            state_d = FIRE;
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                FIRE: begin
                    if (periodic_i && (dly_q != '0)) begin
                        // The FIRE cycle is the first prescaler cycle of the next
                        // period, so pulses land exactly D*TICK_DIV apart.
                        if (TICK_DIV == 1) begin
                            pre_d   = '0;
                            rem_d   = dly_q - DELAY_W'(1);
                            state_d = (dly_q == DELAY_W'(1)) ? FIRE : RUN;
                        end else begin
                            pre_d   = PRE_W'(1);
                            rem_d   = dly_q;
                            state_d = RUN;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pre_d   = '0;
                    rem_d   = '0;
                end
            endcase
        end
    end

    assign timeout_o   = (state_q == FIRE);
    assign busy_o      = (state_q == RUN);
    assign remaining_o = rem_q;

endmodule

// File: rtl/delay_timer_bank.sv
// delay_timer_bank: CHANNELS independent delay timers with flattened buses.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      per-channel load/restart
//   abort      per-channel cancel
//   periodic   per-channel auto-reload (only with DELAY_AUTORELOAD_EN)
//   delay      channel i delay at [i*DELAY_W +: DELAY_W]
//   timeout    per-channel one-cycle expiry pulse
//   busy       per-channel counting flag
//   remaining  channel i ticks left at [i*DELAY_W +: DELAY_W]
// Build option: define DELAY_AUTORELOAD_EN to add the periodic input.
module delay_timer_bank
    import delay_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DELAY_W  = 32,
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           start,
    input  logic [CHANNELS-1:0]           abort,
`ifdef DELAY_AUTORELOAD_EN
    input  logic [CHANNELS-1:0]           periodic,
`endif
    input  logic [CHANNELS*DELAY_W-1:0]   delay,
    output logic [CHANNELS-1:0]           timeout,
    output logic [CHANNELS-1:0]           busy,
    output logic [CHANNELS*DELAY_W-1:0]   remaining
);

    logic [CHANNELS-1:0] periodic_w;

`ifdef DELAY_AUTORELOAD_EN
    assign periodic_w = periodic;
`else
    assign periodic_w = '0;
`endif

    // One channel per bit, slicing the flattened delay/remaining buses.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        delay_channel #(
            .DELAY_W  (DELAY_W),
            .TICK_DIV (TICK_DIV)
        ) u_ch (
            .clk         (clk),
            .rst_n       (reset),
            .start_i     (start[i]),
            .abort_i     (abort[i]),
            .periodic_i  (periodic_w[i]),
            .delay_i     (delay[i*DELAY_W +: DELAY_W]),
            .timeout_o   (timeout[i]),
            .busy_o      (busy[i]),
            .remaining_o (remaining[i*DELAY_W +: DELAY_W])
        );
    end

endmodule

// File: tb/tb_delay_timer_bank.sv
// tb_delay_timer_bank: directed bench for delay_timer_bank with TICK_DIV=4.
// Edge E0 is the posedge at which start is sampled; "k" counts edges after E0
// and outputs are sampled 1 time unit after each edge.
module tb_delay_timer_bank;

    localparam int unsigned CH  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned DIV = 4;

    logic                clk;
    logic                reset;
    logic [CH-1:0]       start;
    logic [CH-1:0]       abort;
    logic [CH-1:0]       periodic;
    logic [CH*DW-1:0]    delay;
    logic [CH-1:0]       timeout;
    logic [CH-1:0]       busy;
    logic [CH*DW-1:0]    remaining;

    int unsigned n_vec;
    int unsigned n_err;

`ifdef DELAY_AUTORELOAD_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif

    delay_timer_bank #(
        .CHANNELS (CH),
        .DELAY_W  (DW),
        .TICK_DIV (DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
`ifdef DELAY_AUTORELOAD_EN
        .periodic  (periodic),
`endif
        .delay     (delay),
        .timeout   (timeout),
        .busy      (busy),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int ch, input logic [DW-1:0] d);
        delay[ch*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rem_of(input int ch);
        return remaining[ch*DW +: DW];
    endfunction

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        start    = '0;
        abort    = '0;
        periodic = '0;
        delay    = '0;

        // Reset state.
        repeat (3) cyc();
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < int'(CH); c++) check($sformatf("rst_rem%0d", c), rem_of(c), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cyc();
            check($sformatf("idle_to k%0d", k), 32'(timeout), 32'd0);
            check($sformatf("idle_busy k%0d", k), 32'(busy), 32'd0);
        end

        // Ch0 D=3: busy through k=11, remaining 3,2,1, pulse at k=12.
        start[0] = 1'b1; set_delay(0, 3);
        cyc(); start[0] = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            check($sformatf("d3_busy k%0d", k), 32'(busy[0]), 32'(k < 12));
            check($sformatf("d3_to k%0d", k), 32'(timeout[0]), 32'(k == 12));
            check($sformatf("d3_rem k%0d", k), rem_of(0), (k < 12) ? 32'(3 - k / 4) : 32'd0);
            cyc();
        end

        // Ch1 D=0: pulse straight after E0, never busy.
        start[1] = 1'b1; set_delay(1, 0);
        cyc(); start[1] = 1'b0;
        check("d0_to", 32'(timeout[1]), 32'd1);
        check("d0_busy", 32'(busy[1]), 32'd0);
        check("d0_rem", rem_of(1), 32'd0);
        cyc();
        check("d0_to_after", 32'(timeout[1]), 32'd0);
        check("d0_busy_after", 32'(busy[1]), 32'd0);

        // Ch2 D=5 and ch3 D=2 together: pulses at k=20 and k=8.
        start[2] = 1'b1; set_delay(2, 5);
        start[3] = 1'b1; set_delay(3, 2);
        cyc(); start[2] = 1'b0; start[3] = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            check($sformatf("c2_to k%0d", k), 32'(timeout[2]), 32'(k == 20));
            check($sformatf("c3_to k%0d", k), 32'(timeout[3]), 32'(k == 8));
            check($sformatf("c2_busy k%0d", k), 32'(busy[2]), 32'(k < 20));
            check($sformatf("c3_busy k%0d", k), 32'(busy[3]), 32'(k < 8));
            cyc();
        end

        // Ch0 D=5 aborted at E0+7: busy drops, no pulse ever.
        start[0] = 1'b1; set_delay(0, 5);
        cyc(); start[0] = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            abort[0] = (k == 7);
            cyc();
            check($sformatf("ab_busy k%0d", k), 32'(busy[0]), 32'(k < 7));
            check($sformatf("ab_to k%0d", k), 32'(timeout[0]), 32'd0);
        end
        abort[0] = 1'b0;

        // Ch0 D=2 restarted with D=2 on its expiry edge E0+8: pulse moves to E0+16.
        start[0] = 1'b1; set_delay(0, 2);
        cyc(); start[0] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            start[0] = (k == 8);
            cyc();
            check($sformatf("rs_to k%0d", k), 32'(timeout[0]), 32'(k == 16));
            check($sformatf("rs_busy k%0d", k), 32'(busy[0]), 32'(k < 16));
        end
        start[0] = 1'b0;

        // Start+abort together at E0+3 with D=1: restart wins, pulse at E0+7.
        start[0] = 1'b1; set_delay(0, 5);
        cyc(); start[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            start[0] = (k == 3);
            abort[0] = (k == 3);
            if (k == 3) set_delay(0, 1);
            cyc();
            check($sformatf("sa_to k%0d", k), 32'(timeout[0]), 32'(k == 7));
            check($sformatf("sa_busy k%0d", k), 32'(busy[0]), 32'(k < 7));
            if (k == 3) check("sa_rem", rem_of(0), 32'd1);
        end
        start[0] = 1'b0; abort[0] = 1'b0;

        // Reset mid-count: immediate IDLE, no pulse after release.
        start[0] = 1'b1; set_delay(0, 3);
        start[1] = 1'b1; set_delay(1, 4);
        cyc(); start = '0;
        repeat (5) cyc();
        check("mr_busy_pre", 32'(busy), 32'h3);
        reset = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_to", 32'(timeout), 32'd0);
        check("mr_rem0", rem_of(0), 32'd0);
        check("mr_rem1", rem_of(1), 32'd0);
        repeat (2) cyc();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check($sformatf("mr_to k%0d", k), 32'(timeout), 32'd0);
            check($sformatf("mr_busy k%0d", k), 32'(busy), 32'd0);
        end

        // Periodic D=2: pulses every 8 cycles until abort (one-shot without the option).
        periodic[0] = 1'b1;
        start[0] = 1'b1; set_delay(0, 2);
        cyc(); start[0] = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            abort[0] = (k == 30);
            cyc();
            check($sformatf("per_to k%0d", k), 32'(timeout[0]),
                  32'((k == 8) || (PER && (k % 8 == 0) && (k < 31))));
        end
        abort[0]    = 1'b0;
        periodic[0] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
